muldiv_seq: RTL and testbench
=============================

// Module: muldiv_seq
// PURPOSE
//  Multi-cycle multiply/divide sequencer owning the MIPS150 HI/LO registers.
//  Executes MULT/MULTU/DIV/DIVU iteratively (radix-2, 32 steps) and MTHI/MTLO.
//  Sits beside the single-cycle ALU in the execute stage.
//  Pipeline control stalls on busy and reads hi/lo for MFHI/MFLO.
// PARAMETERS
//  WIDTH  32  operand / HI / LO width; fixed at 32, not swept.
// PORTS
//  clk    in   1   sole clock; all state updates on rising edge
//  rst    in   1   synchronous, active-high reset
//  start  in   1   issue op; sampled only when busy=0
//  op     in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved
//  a      in   32  rs operand: multiplicand / dividend / MTHI-MTLO data
//  b      in   32  rt operand: multiplier / divisor
//  flush  in   1   abort in-flight op (pipeline squash)
//  busy   out  1   op in flight; pipeline must stall MF*/MT*/MD ops while high
//  done   out  1   one-cycle pulse: hi/lo hold new result this cycle
//  hi     out  32  HI register (product[63:32] / remainder)
//  lo     out  32  LO register (product[31:0] / quotient)
// BEHAVIOUR
//  - Reset: state=IDLE, hi=lo=0, busy=0, done=0, step counter=0.
//  - Reset mid-op aborts the op; hi/lo still clear to 0.
//  - FSM states:
//    IDLE -> RUN on start with op 0-3.
//    RUN (32 cycles, counter 31..0) -> SIGN.
//    SIGN (1 cycle) -> IDLE, writing hi/lo and pulsing done.
//  - Timing, start accepted at edge t:
//    busy=1 for cycles t+1..t+33.
//    At t+34: done=1, hi/lo updated, busy=0; next start accepted at t+34.
//  - a/b are captured at start; later input changes have no effect.
//  - Signed ops (MULT, DIV): iterate on |a|, |b| unsigned, then apply sign in SIGN.
//    Product is negated if signs differ; quotient is negated if signs differ.
//    Remainder takes the sign of the dividend.
//  - Multiply: 64-bit unsigned shift-add; {hi,lo} = a*b as a full 64-bit result.
//  - Divide: restoring shift-subtract; lo=quotient, hi=remainder.
//  - Divide by zero (DIV or DIVU): full 34-cycle latency, then hi=a, lo=32'hFFFF_FFFF.
//  - DIV 32'h8000_0000 / 32'hFFFF_FFFF: lo=32'h8000_0000, hi=0, no trap.
//  - MTHI/MTLO (start while idle): hi (resp. lo) <= a at edge t; done=1 at t+1.
//    These never raise busy.
//  - Reserved op with start: ignored; no state change, no done.
//  - start while busy: ignored; the in-flight op is unaffected.
//  - flush while RUN/SIGN: returns to IDLE next edge; busy=0 next cycle.
//    On flush, hi/lo keep their pre-op values and no done is generated.
//  - flush and start in the same idle cycle: flush wins; start is ignored.
//  - flush coincident with the SIGN cycle: the result is discarded.
//  - done never asserts in the same cycle as rst or flush.
// STRUCTURE
//  - Shared package MulDivOp.vh: `MD_MULT..`MD_MTLO op encodings,
//    FSM state encodings, and STEPS=32.
//  - Sub-module muldiv_step (combinational): one shift-add / shift-subtract
//    iteration over the {rem,acc} 64-bit working register, with mode select.
//  - Top level holds: FSM, 5-bit step counter, operand/sign capture, sign fixup,
//    hi/lo registers.
// TESTING
//  1 MULTU a=FFFFFFFF b=FFFFFFFF -> done at t+34, hi=FFFFFFFE, lo=00000001.
//  2 MULT a=FFFFFFFD(-3) b=7 -> hi=FFFFFFFF, lo=FFFFFFEB; busy high exactly 33 cycles.
//  3 DIV a=FFFFFFF9(-7) b=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
//    DIVU a=7 b=0 -> hi=00000007, lo=FFFFFFFF.
//  4 DIV a=80000000 b=FFFFFFFF -> lo=80000000, hi=00000000.
//    Back-to-back start at t+34 accepted.
//  5 start(DIVU) at t+5 while busy -> ignored.
//    flush at t+10 -> busy=0 at t+11, no done, hi/lo unchanged.
//  6 rst at t+20 mid-MULT -> hi=lo=0, busy=0.
//    Then MTHI a=12345678 -> hi=12345678, done pulse next cycle, busy stays 0.

Source files
------------

// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op encodings,
// FSM states and iteration count.
package muldiv_seq_pkg;

  localparam int STEPS = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SIGN = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration over the {rem,acc} working register:
// shift-add for multiply, restoring shift-subtract for divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] work_in,
  input  logic [WIDTH-1:0]   opnd,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] work_out
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;

  always_comb begin
    // multiply: add multiplicand into the upper half when the multiplier lsb is set
    sum    = {1'b0, work_in[2*WIDTH-1:WIDTH]} + (work_in[0] ? {1'b0, opnd} : '0);
    // divide: remainder shifted left with the next dividend bit brought in
    rem_sh = work_in[2*WIDTH-1:WIDTH-1];
    diff   = rem_sh[WIDTH-1:0] - opnd;
    if (is_div) begin
      if (rem_sh >= {1'b0, opnd})
        work_out = {diff, work_in[WIDTH-2:0], 1'b1};
      else
        work_out = {rem_sh[WIDTH-1:0], work_in[WIDTH-2:0], 1'b0};
    end else begin
      work_out = {sum, work_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO; 32 unsigned
// iterations on magnitudes followed by one sign-fixup cycle.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e             state_reg, state_next;
  logic [4:0]         cnt_reg, cnt_next;
  logic [2*WIDTH-1:0] work_reg, work_next, step_out, prod;
  logic [WIDTH-1:0]   opnd_reg, opnd_next;
  logic [WIDTH-1:0]   a_reg, a_next;
  logic [WIDTH-1:0]   hi_reg, hi_next, lo_reg, lo_next;
  logic               is_div_reg, is_div_next;
  logic               neg_q_reg, neg_q_next, neg_r_reg, neg_r_next;
  logic               bzero_reg, bzero_next;
  logic               done_reg, done_next;
  logic               is_signed;
  logic [WIDTH-1:0]   a_abs, b_abs, quot, rem;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .work_in (work_reg),
    .opnd    (opnd_reg),
    .is_div  (is_div_reg),
    .work_out(step_out)
  );

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    work_next   = work_reg;
    opnd_next   = opnd_reg;
    a_next      = a_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    is_div_next = is_div_reg;
    neg_q_next  = neg_q_reg;
    neg_r_next  = neg_r_reg;
    bzero_next  = bzero_reg;
    done_next   = 1'b0;

    is_signed = (op == OP_MULT) || (op == OP_DIV);
    a_abs     = (is_signed && a[WIDTH-1]) ? -a : a;
    b_abs     = (is_signed && b[WIDTH-1]) ? -b : b;
    prod      = neg_q_reg ? -work_reg : work_reg;
    quot      = neg_q_reg ? -work_reg[WIDTH-1:0] : work_reg[WIDTH-1:0];
    rem       = neg_r_reg ? -work_reg[2*WIDTH-1:WIDTH] : work_reg[2*WIDTH-1:WIDTH];

    case (state_reg)
      ST_IDLE: begin
        if (start && !flush) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              is_div_next = (op == OP_DIV) || (op == OP_DIVU);
              // multiplier (or dividend) sits in the low half; the other operand is held aside
              work_next   = {{WIDTH{1'b0}}, is_div_next ? a_abs : b_abs};
              opnd_next   = is_div_next ? b_abs : a_abs;
              a_next      = a;
              neg_q_next  = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_r_next  = is_signed && a[WIDTH-1];
              bzero_next  = (b == '0);
              cnt_next    = 5'(STEPS - 1);
              state_next  = ST_RUN;
            end
            OP_MTHI: begin
              hi_next   = a;
              done_next = 1'b1;
            end
            OP_MTLO: begin
              lo_next   = a;
              done_next = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_next = ST_IDLE;
        end else begin
          work_next = step_out;
          cnt_next  = cnt_reg - 5'd1;
          if (cnt_reg == '0)
            state_next = ST_SIGN;
        end
      end
      ST_SIGN: begin
        state_next = ST_IDLE;
        if (!flush) begin
          done_next = 1'b1;
          if (is_div_reg) begin
            if (bzero_reg) begin
              hi_next = a_reg;
              lo_next = '1;
            end else begin
              hi_next = rem;
              lo_next = quot;
            end
          end else begin
            {hi_next, lo_next} = prod;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      work_reg   <= '0;
      opnd_reg   <= '0;
      a_reg      <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      bzero_reg  <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      work_reg   <= work_next;
      opnd_reg   <= opnd_next;
      a_reg      <= a_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      is_div_reg <= is_div_next;
      neg_q_reg  <= neg_q_next;
      neg_r_reg  <= neg_r_next;
      bzero_reg  <= bzero_next;
      done_reg   <= done_next;
    end
  end

  assign busy = (state_reg != ST_IDLE);
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: hand-computed HI/LO results, latency,
// busy/done timing, flush, reset and ignored-start cases.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .flush(flush),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // counts busy cycles from the current cycle until idle (bounded)
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 60) begin
      n++;
      tick();
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    start = 1'b1; op = o; a = av; b = bv;
    tick();
    start = 1'b0; a = $urandom; b = $urandom;
    chk({tag, " done_low"}, done, 1'b0);
    wait_idle(n);
    chk({tag, " busy_cycles"}, n, 33);
    chk({tag, " done"}, done, 1'b1);
    chk({tag, " hi"}, hi, exp_hi);
    chk({tag, " lo"}, lo, exp_lo);
    $display("%s op=%0d a=%h b=%h busy=%0d hi=%h lo=%h", tag, o, av, bv, n, hi, lo);
  endtask

  initial begin
    int n;
    int done_seen;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (3) tick();
    chk("reset hi", hi, 32'h0);
    chk("reset lo", lo, 32'h0);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    $display("reset hi=%h lo=%h busy=%0d done=%0d", hi, lo, busy, done);
    rst = 1'b0;
    tick();

    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg",  3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("mult_min",  3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("div_neg",   3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_negb",  3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu_zero", 3'd3, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF);
    run_op("div_zero",  3'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div_ovf",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("divu_b2b",  3'd3, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E);
    run_op("multu_5x6", 3'd1, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 32'h0000_001E);

    // start while busy is ignored
    start = 1'b1; op = 3'd1; a = 32'd9; b = 32'd9;
    tick();
    start = 1'b0;
    repeat (3) tick();
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd3;
    tick();
    start = 1'b0;
    wait_idle(n);
    chk("busy_start busy_cycles", n + 4, 33);
    chk("busy_start done", done, 1'b1);
    chk("busy_start hi", hi, 32'h0);
    chk("busy_start lo", lo, 32'd81);
    $display("busy_start ignored hi=%h lo=%h", hi, lo);
    tick();

    // flush mid-run
    start = 1'b1; op = 3'd1; a = 32'd5; b = 32'd6;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_run busy", busy, 1'b0);
    chk("flush_run done", done, 1'b0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_seen++;
      tick();
    end
    chk("flush_run no_done", done_seen, 0);
    chk("flush_run lo", lo, 32'd81);
    $display("flush_run hi=%h lo=%h", hi, lo);

    // flush coincident with the sign cycle
    start = 1'b1; op = 3'd1; a = 32'd5; b = 32'd6;
    tick();
    start = 1'b0;
    repeat (32) tick();
    chk("flush_sign busy", busy, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_sign done", done, 1'b0);
    chk("flush_sign busy_after", busy, 1'b0);
    chk("flush_sign lo", lo, 32'd81);
    $display("flush_sign hi=%h lo=%h", hi, lo);

    // flush and start together while idle
    flush = 1'b1; start = 1'b1; op = 3'd5; a = 32'hDEAD_BEEF;
    tick();
    flush = 1'b0; start = 1'b0;
    chk("flush_start done", done, 1'b0);
    chk("flush_start lo", lo, 32'd81);
    chk("flush_start busy", busy, 1'b0);
    $display("flush_start lo=%h", lo);

    // reserved ops
    for (int r = 6; r < 8; r++) begin
      start = 1'b1; op = 3'(r); a = 32'h1111_2222; b = 32'h3;
      tick();
      start = 1'b0;
      chk("reserved busy", busy, 1'b0);
      chk("reserved done", done, 1'b0);
      chk("reserved hilo", {hi, lo}, {32'h0, 32'd81});
      $display("reserved op=%0d hi=%h lo=%h", r, hi, lo);
    end

    // reset mid-op
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
    tick();
    start = 1'b0;
    repeat (19) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid hi", hi, 32'h0);
    chk("rst_mid lo", lo, 32'h0);
    chk("rst_mid busy", busy, 1'b0);
    chk("rst_mid done", done, 1'b0);
    $display("rst_mid hi=%h lo=%h busy=%0d", hi, lo, busy);

    // MTHI / MTLO
    start = 1'b1; op = 3'd4; a = 32'h1234_5678;
    tick();
    start = 1'b0;
    chk("mthi hi", hi, 32'h1234_5678);
    chk("mthi done", done, 1'b1);
    chk("mthi busy", busy, 1'b0);
    tick();
    chk("mthi done_low", done, 1'b0);
    $display("mthi hi=%h", hi);
    start = 1'b1; op = 3'd5; a = 32'hCAFE_0001;
    tick();
    start = 1'b0;
    chk("mtlo lo", lo, 32'hCAFE_0001);
    chk("mtlo hi_kept", hi, 32'h1234_5678);
    chk("mtlo done", done, 1'b1);
    $display("mtlo lo=%h", lo);
    tick();

    run_op("mult_after", 3'd0, 32'h0000_0003, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFF4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
